fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/common_pkg.sv | 17 +
 rtl/pipes_pkg.sv | 21 ++
 rtl/fetch_skid.sv | 52 +++++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/common_pkg.sv
// Shared scalar types and instruction-bus transaction records.
package common;

  typedef logic [63:0] word_t;
  typedef logic [31:0] u32;

  typedef struct packed {
    logic  valid;
    word_t addr;
  } ibus_req_t;

  typedef struct packed {
    logic data_ok;
    u32   data;
  } ibus_resp_t;

endpackage

// File: rtl/pipes_pkg.sv
// Pipeline payload types and fetch FSM state encoding.
package pipes;

  import common::*;

  typedef struct packed {
    word_t pc;
    u32    raw_instr;
  } fetch_data_t;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t FETCH_REQ  = 2'd0;
  localparam fetch_state_t FETCH_KILL = 2'd1;
  localparam fetch_state_t FETCH_HOLD = 2'd2;

  function automatic word_t next_word(word_t a);
    return a + 64'd4;
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// Two-entry fetch buffer: an output slot backed by one skid entry.
module fetch_skid
  import pipes::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  input  fetch_data_t in_data,
  output logic        out_free,
  output logic        out_valid,
  input  logic        out_ready,
  output fetch_data_t out_data
);

  logic        out_valid_q;
  fetch_data_t out_q;
  logic        skid_valid_q;
  fetch_data_t skid_q;

  assign out_free  = !out_valid_q || out_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (out_free) begin
      // Skid entry is older than anything arriving, so it always goes first.
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (in_valid) begin
        out_q       <= in_data;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (in_valid) begin
      skid_q       <= in_data;
      skid_valid_q <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: bus request FSM, PC/redirect handling, buffered output.
module fetch_unit
  import common::*;
  import pipes::*;
#(
  parameter word_t PCINIT = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr
);

  fetch_state_t state_q, state_d;
  word_t        addr_q, addr_d;
  word_t        pc_q, pc_d;
  word_t        target;
  ibus_req_t    ireq;
  ibus_resp_t   iresp;
  logic         push;
  logic         out_free;
  fetch_data_t  in_data;
  fetch_data_t  out_data;

  assign iresp   = '{data_ok: iresp_data_ok, data: iresp_data};
  assign target  = redirect_pc & ~word_t'(3);
  assign in_data = '{pc: addr_q, raw_instr: iresp.data};

  assign ireq.valid = ((state_q == FETCH_REQ) || (state_q == FETCH_KILL)) && !reset;
  assign ireq.addr  = addr_q;
  assign ireq_valid = ireq.valid;
  assign ireq_addr  = ireq.addr;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pc_d    = pc_q;
    push    = 1'b0;
    case (state_q)
      FETCH_REQ: begin
        if (redirect_valid) begin
          if (iresp.data_ok) begin
            addr_d = target;
          end else begin
            pc_d    = target;
            state_d = FETCH_KILL;
          end
        end else if (iresp.data_ok) begin
          push   = 1'b1;
          addr_d = next_word(addr_q);
          if (!out_free) state_d = FETCH_HOLD;
        end
      end
      FETCH_KILL: begin
        // The stale response must be consumed before the new address goes out.
        if (iresp.data_ok) begin
          addr_d  = redirect_valid ? target : pc_q;
          state_d = FETCH_REQ;
        end else if (redirect_valid) begin
          pc_d = target;
        end
      end
      FETCH_HOLD: begin
        if (redirect_valid) begin
          addr_d  = target;
          state_d = FETCH_REQ;
        end else if (out_ready) begin
          state_d = FETCH_REQ;
        end
      end
      default: state_d = FETCH_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH_REQ;
      addr_q  <= PCINIT;
      pc_q    <= PCINIT;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
    end
  end

  fetch_skid u_skid (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .in_valid (push),
    .in_data  (in_data),
    .out_free (out_free),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  assign out_pc    = out_data.pc;
  assign out_instr = out_data.raw_instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, corner sequences, random run.
module tb_fetch_unit;

  localparam logic [63:0] PCINIT = 64'h0000_0000_8000_0000;
  localparam logic [63:0] B      = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;

  int checks   = 0;
  int failures = 0;

  fetch_unit #(.PCINIT(PCINIT)) dut (
    .clk           (clk),
    .reset         (reset),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    int          seg;
    logic        dok;
    logic        rdy;
    logic        rv;
    logic [63:0] rpc;
    logic        ev;
    logic [63:0] ea;
    logic        eov;
    logic [63:0] epc;
  } vec_t;

  vec_t vecs[$];

  // Memory image: every word is a distinct function of its address.
  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic dok, input logic rdy, input logic rv, input logic [63:0] rpc);
    iresp_data_ok  = dok;
    iresp_data     = dok ? instr_of(ireq_addr) : 32'h0;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic add(input int seg, input logic dok, input logic rdy, input logic rv,
                     input logic [63:0] rpc, input logic ev, input logic [63:0] ea,
                     input logic eov, input logic [63:0] epc);
    vec_t v;
    v.seg = seg; v.dok = dok; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.ea = ea; v.eov = eov; v.epc = epc;
    vecs.push_back(v);
  endtask

  initial begin
    int cur;
    logic [63:0] exp_pc;
    logic prev_iv, prev_dok, prev_ov, prev_rdy, prev_rv;
    logic [63:0] prev_ia, prev_opc;
    logic dok, rdy, rv;
    logic [63:0] rpc;
    int gap, handshakes;

    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 64'h0);

    // seg, dok, rdy, rv, rpc | exp ivalid, iaddr, ovalid, opc
    // Back-to-back streaming.
    add(0, 1, 1, 0, 0, 1, B + 'h000, 0, 0);
    add(0, 1, 1, 0, 0, 1, B + 'h004, 1, B + 'h000);
    add(0, 1, 1, 0, 0, 1, B + 'h008, 1, B + 'h004);
    add(0, 0, 1, 0, 0, 1, B + 'h00C, 1, B + 'h008);
    // Backpressure into skid and HOLD, then drain in order.
    add(1, 1, 0, 0, 0, 1, B + 'h000, 0, 0);
    add(1, 1, 0, 0, 0, 1, B + 'h004, 1, B + 'h000);
    add(1, 0, 0, 0, 0, 0, B + 'h008, 1, B + 'h000);
    add(1, 0, 1, 0, 0, 0, B + 'h008, 1, B + 'h000);
    add(1, 1, 1, 0, 0, 1, B + 'h008, 1, B + 'h004);
    add(1, 0, 1, 0, 0, 1, B + 'h00C, 1, B + 'h008);
    add(1, 0, 0, 0, 0, 1, B + 'h00C, 0, 0);
    // Redirect with a request outstanding: KILL until the stale response.
    add(2, 1, 1, 0, 0,          1, B + 'h000, 0, 0);
    add(2, 1, 1, 0, 0,          1, B + 'h004, 1, B + 'h000);
    add(2, 0, 1, 1, B + 'h100,  1, B + 'h008, 1, B + 'h004);
    add(2, 0, 1, 0, 0,          1, B + 'h008, 0, 0);
    add(2, 1, 1, 0, 0,          1, B + 'h008, 0, 0);
    add(2, 1, 1, 0, 0,          1, B + 'h100, 0, 0);
    add(2, 0, 1, 0, 0,          1, B + 'h104, 1, B + 'h100);
    // Unaligned redirect coinciding with data_ok.
    add(3, 1, 1, 0, 0,          1, B + 'h000, 0, 0);
    add(3, 1, 1, 1, B + 'h203,  1, B + 'h004, 1, B + 'h000);
    add(3, 1, 1, 0, 0,          1, B + 'h200, 0, 0);
    add(3, 0, 1, 0, 0,          1, B + 'h204, 1, B + 'h200);
    // Two redirects while in KILL; only the last target is fetched.
    add(4, 0, 1, 1, B + 'h300,  1, B + 'h000, 0, 0);
    add(4, 0, 1, 1, B + 'h400,  1, B + 'h000, 0, 0);
    add(4, 1, 1, 0, 0,          1, B + 'h000, 0, 0);
    add(4, 1, 1, 0, 0,          1, B + 'h400, 0, 0);
    add(4, 0, 1, 0, 0,          1, B + 'h404, 1, B + 'h400);

    cur = -1;
    foreach (vecs[i]) begin
      if (vecs[i].seg != cur) begin
        do_reset();
        cur = vecs[i].seg;
        if (i == 0) begin
          check("reset_out_pc", out_pc, 64'h0);
          check("reset_out_instr", {32'h0, out_instr}, 64'h0);
        end
      end
      check($sformatf("v%0d_ireq_valid", i), {63'h0, ireq_valid}, {63'h0, vecs[i].ev});
      check($sformatf("v%0d_ireq_addr", i), ireq_addr, vecs[i].ea);
      check($sformatf("v%0d_out_valid", i), {63'h0, out_valid}, {63'h0, vecs[i].eov});
      if (vecs[i].eov) begin
        check($sformatf("v%0d_out_pc", i), out_pc, vecs[i].epc);
        check($sformatf("v%0d_out_instr", i), {32'h0, out_instr}, {32'h0, instr_of(vecs[i].epc)});
      end
      drive(vecs[i].dok, vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
      @(negedge clk);
    end

    // Asynchronous reset while in HOLD.
    do_reset();
    drive(1, 0, 0, 0);
    @(negedge clk);
    drive(1, 0, 0, 0);
    @(negedge clk);
    check("hold_ireq_valid", {63'h0, ireq_valid}, 64'h0);
    check("hold_out_valid", {63'h0, out_valid}, 64'h1);
    drive(0, 0, 0, 0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_out_valid", {63'h0, out_valid}, 64'h0);
    check("async_rst_ireq_valid", {63'h0, ireq_valid}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_ireq_valid", {63'h0, ireq_valid}, 64'h1);
    check("post_rst_ireq_addr", ireq_addr, PCINIT);

    // Address wrap at the top of the 64-bit space.
    drive(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFE);
    @(negedge clk);
    drive(1, 1, 0, 0);
    @(negedge clk);
    check("wrap_ireq_addr_top", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    drive(1, 1, 0, 0);
    @(negedge clk);
    check("wrap_ireq_addr_zero", ireq_addr, 64'h0);
    check("wrap_out_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_out_valid", {63'h0, out_valid}, 64'h1);
    drive(0, 0, 0, 0);

    // Random run against a stream-level model: delivered PCs form +4 runs
    // restarted at each aligned redirect target.
    do_reset();
    exp_pc = PCINIT;
    gap = 0;
    handshakes = 0;
    prev_iv = 1'b0; prev_dok = 1'b0; prev_ov = 1'b0; prev_rdy = 1'b0; prev_rv = 1'b0;
    prev_ia = '0; prev_opc = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (prev_iv && !prev_dok) begin
        check("rnd_bus_hold_valid", {63'h0, ireq_valid}, 64'h1);
        check("rnd_bus_hold_addr", ireq_addr, prev_ia);
      end
      if (prev_ov && !prev_rdy && !prev_rv) begin
        check("rnd_out_hold_valid", {63'h0, out_valid}, 64'h1);
        check("rnd_out_hold_pc", out_pc, prev_opc);
      end
      if (ireq_valid) check("rnd_addr_align", {62'h0, ireq_addr[1:0]}, 64'h0);
      dok = ireq_valid && ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 3) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
      else rpc = B + 64'($urandom_range(0, 4095));
      drive(dok, rdy, rv, rpc);
      if (out_valid && rdy) begin
        check("rnd_out_pc", out_pc, exp_pc);
        check("rnd_out_instr", {32'h0, out_instr}, {32'h0, instr_of(exp_pc)});
        exp_pc = exp_pc + 64'd4;
        handshakes++;
        gap = 0;
      end else begin
        gap++;
      end
      if (rv) exp_pc = rpc & ~64'h3;
      if (gap > 200) begin
        checks++;
        failures++;
        $display("FAIL rnd_progress no handshake for %0d cycles required <=200", gap);
        break;
      end
      prev_iv = ireq_valid; prev_ia = ireq_addr; prev_dok = dok;
      prev_ov = out_valid; prev_opc = out_pc; prev_rdy = rdy; prev_rv = rv;
      @(negedge clk);
    end
    checks++;
    if (handshakes < 500) begin
      failures++;
      $display("FAIL rnd_throughput handshakes=%0d required>=500", handshakes);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
